// File: rtl/checker_pkg.sv
// Shared definitions for the scan checker: FSM state encoding and the
// bit positions inside the cctrl status byte.
package checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int CC_FIN  = 0;  // scan finished
  localparam int CC_ERR  = 1;  // MPU reported an error
  localparam int CC_TMO  = 2;  // MPU did not answer in time
  localparam int CC_WRAP = 3;  // next address would leave the address space
  localparam int CC_ZERO = 4;  // zero-length scan requested

endpackage

// File: rtl/checker_scan_if.sv
// Control, status and MPU handshake bundle of the scan checker.
// master: the scanner itself; slave: the controller/MPU environment.
interface checker_scan_if #(
  parameter int ADDR_W = 64,
  parameter int LEN_W  = 16
);
  logic [1:0]        cmode;
  logic              cstart;
  logic [ADDR_W-1:0] caddr;
  logic [LEN_W-1:0]  clen;
  logic              cend;
  logic [7:0]        cctrl;
  logic [ADDR_W-1:0] cfail_addr;
  logic              mpu_en;
  logic              mpu_req;
  logic [ADDR_W-1:0] mpu_addr;
  logic              mpu_ack;
  logic              mpu_err;

  modport master (
    input  cmode, cstart, caddr, clen, mpu_ack, mpu_err,
    output cend, cctrl, cfail_addr, mpu_en, mpu_req, mpu_addr
  );

  modport slave (
    output cmode, cstart, caddr, clen, mpu_ack, mpu_err,
    input  cend, cctrl, cfail_addr, mpu_en, mpu_req, mpu_addr
  );
endinterface

// File: rtl/checker_timer.sv
// Wait-cycle counter for the scan checker's MPU timeout.
// Only built with CHECKER_SCAN_TIMEOUT_EN defined.
`ifdef CHECKER_SCAN_TIMEOUT_EN
module checker_timer #(
  parameter int W = 12
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  logic [W-1:0] count_reg;

  // Count enabled cycles; clear has priority so a fresh wait starts at zero.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_reg + W'(1);
    end
  end

  assign expired = &count_reg;
endmodule
`endif

// File: rtl/checker_scan.sv
// Scan checker: walks base + i*STEP for clen words, asking the MPU to check
// each address, and reports the outcome in cctrl / cfail_addr with a cend pulse.
// Optional macro CHECKER_SCAN_TIMEOUT_EN adds a per-word MPU timeout.
module checker_scan
  import checker_pkg::*;
#(
  parameter logic [1:0] MODE   = 2'b00,
  parameter int         ADDR_W = 64,
  parameter int         LEN_W  = 16,
  parameter int         STEP   = 8,
  parameter int         TMO_W  = 12
) (
  input  logic           sys_clk,
  input  logic           sys_rst,
  checker_scan_if.master bus
);
  // STEP is a power of two, so index*STEP is a shift. The sum is kept wide
  // enough that any carry out of ADDR_W bits is visible as a wrap.
  localparam int SHIFT = $clog2(STEP);
  localparam int SUM_W = ADDR_W + LEN_W + SHIFT + 1;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] base_reg;
  logic [LEN_W-1:0]  len_reg;
  logic [LEN_W-1:0]  index_reg;
  logic [LEN_W-1:0]  index_inc;
  logic [7:0]        cctrl_reg;
  logic [ADDR_W-1:0] fail_reg;
  logic [SUM_W-1:0]  addr_full;
  logic              addr_wrap;
  logic              start_ok;
  logic              tmo_expired;

  assign addr_full = SUM_W'(base_reg) + (SUM_W'(index_reg) << SHIFT);
  assign addr_wrap = |addr_full[SUM_W-1:ADDR_W];
  assign index_inc = index_reg + LEN_W'(1);
  assign start_ok  = bus.cstart && (bus.cmode == MODE);

`ifdef CHECKER_SCAN_TIMEOUT_EN
  logic tmo_clear;
  logic tmo_enable;

  // Outside REQ the counter is held at zero, which also covers REQ entry.
  assign tmo_clear  = (state_reg != ST_REQ) || bus.mpu_ack;
  assign tmo_enable = (state_reg == ST_REQ) && !bus.mpu_ack;

  checker_timer #(.W(TMO_W)) u_timer (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .clear   (tmo_clear),
    .enable  (tmo_enable),
    .expired (tmo_expired)
  );
`else
  // No timer: the scanner waits for the MPU indefinitely.
  assign tmo_expired = (TMO_W < 0);
`endif

  // State register.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; wrap and timeout pre-empt the MPU answer.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start_ok) begin
          state_next = (bus.clen == '0) ? ST_DONE : ST_REQ;
        end
      end
      ST_REQ: begin
        if (addr_wrap || tmo_expired) begin
          state_next = ST_DONE;
        end else if (bus.mpu_ack) begin
          if (bus.mpu_err || (index_inc == len_reg)) begin
            state_next = ST_DONE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Scan registers and status capture.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      base_reg  <= '0;
      len_reg   <= '0;
      index_reg <= '0;
      cctrl_reg <= '0;
      fail_reg  <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start_ok) begin
            base_reg           <= bus.caddr;
            len_reg            <= bus.clen;
            index_reg          <= '0;
            fail_reg           <= '0;
            cctrl_reg          <= '0;
            cctrl_reg[CC_ZERO] <= (bus.clen == '0);
          end
        end
        ST_REQ: begin
          if (addr_wrap) begin
            cctrl_reg[CC_WRAP] <= 1'b1;
          end else if (tmo_expired) begin
            cctrl_reg[CC_TMO] <= 1'b1;
            fail_reg          <= addr_full[ADDR_W-1:0];
          end else if (bus.mpu_ack) begin
            if (bus.mpu_err) begin
              cctrl_reg[CC_ERR] <= 1'b1;
              fail_reg          <= addr_full[ADDR_W-1:0];
            end else begin
              index_reg <= index_inc;
            end
          end
        end
        default: ;
      endcase
      if ((state_reg != ST_DONE) && (state_next == ST_DONE)) begin
        cctrl_reg[CC_FIN] <= 1'b1;
      end
    end
  end

  // Outputs decoded from state; a request is withheld on wrap or timeout.
  always_comb begin
    bus.cend     = 1'b0;
    bus.mpu_en   = 1'b0;
    bus.mpu_req  = 1'b0;
    bus.mpu_addr = '0;
    case (state_reg)
      ST_REQ: begin
        bus.mpu_en = 1'b1;
        if (!addr_wrap && !tmo_expired) begin
          bus.mpu_req  = 1'b1;
          bus.mpu_addr = addr_full[ADDR_W-1:0];
        end
      end
      ST_DONE: begin
        bus.mpu_en = 1'b1;
        bus.cend   = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.cctrl      = cctrl_reg;
  assign bus.cfail_addr = fail_reg;

endmodule
